needs_engine: RTL

Generates and maintains the five 4-bit need levels (hunger, happiness, health, hygiene, energy) that feed the status evaluator. Each need ages upward at its own rate from a shared game-tick prescaler; player care actions lower needs. The engine watches the evaluator's status word and freezes permanently once the pet is dead. Higher need value means worse (0 = fully satisfied, 15 = fatal).

---
 rtl/needs_engine.sv | 108 ++++++++++
 1 files changed

// File: rtl/needs_engine.sv
// rtl/needs_engine.sv - pet need-level generator with aging, care actions and death freeze
//
// Purpose: keeps five 4-bit need levels (0 = satisfied, 15 = fatal). A shared
// prescaler produces game ticks. Each need ages +1 every RATE ticks. Rising
// edges on the care inputs lower the matching need. Once the evaluator reports
// death, the engine freezes until reset.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   feed/play/medicine/        care actions (level inputs, rising-edge detected)
//   clean/sleep
//   status[6:0]                evaluator status word, 7'h7F means dead
//   hunger/happiness/health/   need levels
//   hygiene/energy[3:0]
//   tick                       one-cycle pulse per game tick (registered)
//   dead                       sticky death flag
module needs_engine #(
  parameter int TICK_DIV     = 1000000,
  parameter int HUNGER_RATE  = 2,
  parameter int HAPPY_RATE   = 3,
  parameter int HEALTH_RATE  = 8,
  parameter int HYGIENE_RATE = 4,
  parameter int ENERGY_RATE  = 5,
  parameter int CARE_AMOUNT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       feed,
  input  logic       play,
  input  logic       medicine,
  input  logic       clean,
  input  logic       sleep,
  input  logic [6:0] status,
  output logic [3:0] hunger,
  output logic [3:0] happiness,
  output logic [3:0] health,
  output logic [3:0] hygiene,
  output logic [3:0] energy,
  output logic       tick,
  output logic       dead
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  // Index order shared by all per-need arrays:
  // 0 hunger/feed, 1 happiness/play, 2 health/medicine, 3 hygiene/clean, 4 energy/sleep
  localparam int RATE [5] = '{HUNGER_RATE, HAPPY_RATE, HEALTH_RATE, HYGIENE_RATE, ENERGY_RATE};

  logic [PW-1:0] presc;
  logic          tick_ev;
  logic [7:0]    rcnt [5];
  logic [3:0]    lvl  [5];
  logic [3:0]    nxt  [5];
  logic [4:0]    act_in, act_q, fire, age;

  function automatic logic [3:0] clamp15(input int v);
    if (v < 0)       return 4'd0;
    else if (v > 15) return 4'd15;
    else             return 4'(v);
  endfunction

  assign act_in  = {sleep, clean, medicine, play, feed};
  assign tick_ev = (presc == PW'(TICK_DIV - 1)) && !dead;
  // Care edges are suppressed while dead even though the edge registers keep sampling.
  assign fire    = act_in & ~act_q & {5{~dead}};

  always_comb begin
    age = '0;
    for (int i = 0; i < 5; i++) begin
      age[i] = tick_ev && (rcnt[i] == 8'(RATE[i] - 1));
      // All same-cycle contributions are summed in full-width signed arithmetic
      // before clamping, so e.g. aging+play+sleep on energy nets out correctly.
      nxt[i] = clamp15(int'(lvl[i]) + int'(age[i])
                       - (fire[i] ? CARE_AMOUNT : 0)
                       + ((i == 4 && fire[1]) ? 1 : 0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
      dead  <= 1'b0;
      act_q <= '0;
      for (int i = 0; i < 5; i++) begin
        rcnt[i] <= '0;
        lvl[i]  <= '0;
      end
    end else begin
      act_q <= act_in;
      tick  <= tick_ev;
      if (status == 7'h7F) dead <= 1'b1;
      if (!dead) begin
        presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
        for (int i = 0; i < 5; i++) begin
          lvl[i] <= nxt[i];
          if (tick_ev) rcnt[i] <= age[i] ? 8'd0 : rcnt[i] + 8'd1;
        end
      end
    end
  end

  assign hunger    = lvl[0];
  assign happiness = lvl[1];
  assign health    = lvl[2];
  assign hygiene   = lvl[3];
  assign energy    = lvl[4];

endmodule
